// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between ALU control (master) and the shift sequencer (slave).
// op_type encodes 00 srl, 01 sll, 10 sra, 11 illegal.
interface shift_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] a;
   logic [SHW-1:0]   shamt;
   logic [1:0]       op_type;
   logic             ready;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] r;

   modport master (
      output start, abort, a, shamt, op_type,
      input  ready, busy, done, err, r
   );

   modport slave (
      input  start, abort, a, shamt, op_type,
      output ready, busy, done, err, r
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle srl/sll/sra unit: shifts at most STEP bits per cycle until the amount is used up.
// Outputs decode from registered state only, so the pipeline can stall on busy without comb loops.
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5,
   parameter int STEP  = 1
) (
   input logic                clk,
   input logic                rst_n,
   shift_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
   typedef enum logic [1:0] {OP_SRL = 2'b00, OP_SLL = 2'b01, OP_SRA = 2'b10, OP_ILL = 2'b11} op_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   op_e              typ_q, typ_d;

   logic             accept;
   logic             last_step;
   logic [SHW-1:0]   step_k;

   assign accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.abort;
   // k = min(STEP, cnt) keeps cnt from ever wrapping below zero.
   assign step_k    = (cnt_q < SHW'(STEP)) ? cnt_q : SHW'(STEP);
   assign last_step = (cnt_q <= SHW'(STEP));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = ((bus.shamt == '0) || (op_e'(bus.op_type) == OP_ILL)) ? S_DONE : S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (last_step) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state_q == S_IDLE) || (state_q == S_DONE);
      bus.busy  = (state_q == S_SHIFT);
      bus.done  = (state_q == S_DONE);
      bus.err   = (state_q == S_DONE) && (typ_q == OP_ILL);
      bus.r     = acc_q;
   end

   // Datapath: load on accept, otherwise one bounded step per SHIFT cycle; an aborted op freezes acc.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      typ_d = typ_q;
      if (accept) begin
         acc_d = bus.a;
         cnt_d = bus.shamt;
         typ_d = op_e'(bus.op_type);
      end else if ((state_q == S_SHIFT) && !bus.abort) begin
         cnt_d = cnt_q - step_k;
         case (typ_q)
            OP_SRL:  acc_d = acc_q >> step_k;
            OP_SLL:  acc_d = acc_q << step_k;
            OP_SRA:  acc_d = WIDTH'($signed(acc_q) >>> step_k);
            default: acc_d = acc_q;
         endcase
      end
   end

   // NOTE: the accumulator is reset because r must read zero after reset, not just be don't-care.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         typ_q <= OP_SRL;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         typ_q <= typ_d;
      end
   end

endmodule
